// File: rtl/pipe_shifter_if.sv
// pipe_shifter_if: operand/result handshake bundle for pipe_shifter
// master drives operations and out_ready; slave is the shifter
interface pipe_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;

    modport master (
        output in_valid,
        output in_a,
        output in_shamt,
        output in_op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_shamt,
        input  in_op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_zero
    );
endinterface

// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter, one stage per shamt bit
// SLL / SRL / SRA / ROR with valid/ready on both sides
module pipe_shifter #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    pipe_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] word_t;

    logic  adv;
    logic  last_v;
    word_t last_d;

    // Shift by a fixed power-of-two distance s.
    // SRA fills from the sign captured at entry, not from d.
    function automatic word_t step(
        input word_t      d,
        input logic [1:0] op,
        input logic       sg,
        input int         s
    );
        word_t ones;
        word_t r;
        ones = '1;
        r    = d;
        unique case (op)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = (d >> s) | (sg ? ~(ones >> s) : '0);
            2'b11: r = (d >> s) | (d << (WIDTH - s));
        endcase
        return r;
    endfunction

    // Whole pipeline moves together; a stalled head freezes everything.
    assign adv = !last_v || bus.out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_st
        localparam int S = 1 << k;

        logic             v_in;
        word_t            d_in;
        logic [1:0]       op_in;
        logic             sg_in;
        logic [SHW-1-k:0] rem_in;
        word_t            d_nx;

        logic             v_q;
        word_t            d_q;

        if (k == 0) begin : g_src
            assign v_in   = bus.in_valid;
            assign d_in   = bus.in_a;
            assign op_in  = bus.in_op;
            assign sg_in  = bus.in_a[WIDTH-1];
            assign rem_in = bus.in_shamt;
        end else begin : g_src
            assign v_in   = g_st[k-1].v_q;
            assign d_in   = g_st[k-1].d_q;
            assign op_in  = g_st[k-1].g_meta.op_q;
            assign sg_in  = g_st[k-1].g_meta.sg_q;
            assign rem_in = g_st[k-1].g_meta.rem_q;
        end

        assign d_nx = rem_in[0] ? step(d_in, op_in, sg_in, S) : d_in;

        // Stage k register: valid and partially shifted data.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                d_q <= d_nx;
            end
        end

        if (k < SHW - 1) begin : g_meta
            logic [1:0]       op_q;
            logic             sg_q;
            logic [SHW-2-k:0] rem_q;

            // Carry op, entry sign and the not-yet-used shamt bits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    op_q  <= '0;
                    sg_q  <= 1'b0;
                    rem_q <= '0;
                end else if (adv) begin
                    op_q  <= op_in;
                    sg_q  <= sg_in;
                    rem_q <= rem_in[SHW-1-k:1];
                end
            end
        end
    end

    assign last_v = g_st[SHW-1].v_q;
    assign last_d = g_st[SHW-1].d_q;

    assign bus.in_ready   = adv;
    assign bus.out_valid  = last_v;
    assign bus.out_result = last_d;
    assign bus.out_zero   = (last_d == '0);
endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: scoreboard bench for pipe_shifter
// runs the same suite on a 32-bit and an 8-bit instance
module tb_pipe_shifter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_shifter_if #(.WIDTH(32)) b32();
    pipe_shifter_if #(.WIDTH(8))  b8();

    pipe_shifter #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    pipe_shifter #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));

    logic        w8;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_a;
    logic [4:0]  d_shamt;
    logic [1:0]  d_op;

    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zero;
    logic        i_ready;

    assign b32.in_valid  = d_valid && !w8;
    assign b32.in_a      = d_a;
    assign b32.in_shamt  = d_shamt;
    assign b32.in_op     = d_op;
    assign b32.out_ready = w8 ? 1'b1 : d_ready;

    assign b8.in_valid   = d_valid && w8;
    assign b8.in_a       = d_a[7:0];
    assign b8.in_shamt   = d_shamt[2:0];
    assign b8.in_op      = d_op;
    assign b8.out_ready  = w8 ? d_ready : 1'b1;

    assign o_valid  = w8 ? b8.out_valid : b32.out_valid;
    assign o_result = w8 ? {24'h0, b8.out_result} : b32.out_result;
    assign o_zero   = w8 ? b8.out_zero : b32.out_zero;
    assign i_ready  = w8 ? b8.in_ready : b32.in_ready;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [31:0] q[$];

    always @(posedge clk) cyc++;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [31:0] a, int sh,
                                          logic [1:0] op, int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'b00: r[i] = (i >= sh) ? a[i-sh] : 1'b0;
                2'b01: r[i] = (i + sh < w) ? a[i+sh] : 1'b0;
                2'b10: r[i] = (i + sh < w) ? a[i+sh] : a[w-1];
                default: r[i] = a[(i+sh)%w];
            endcase
        end
        return r;
    endfunction

    logic [31:0] held;
    logic        held_v = 1'b0;

    // Monitor: pop on every output transfer, watch stalled outputs.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", {31'h0, o_valid}, 32'h1);
                check("hold_result", o_result, held);
            end
            if (o_valid && d_ready) begin
                held_v = 1'b0;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious: got %h expected no output", o_result);
                end else begin
                    e = q.pop_front();
                    check("result", o_result, e);
                    check("zero", {31'h0, o_zero}, {31'h0, e == 0});
                end
            end else if (o_valid) begin
                held   = o_result;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Present one op and hold until accepted; valid stays high.
    task automatic send(logic [31:0] a, int sh, logic [1:0] op,
                        logic [31:0] exp);
        int n;
        d_valid = 1'b1;
        d_a     = a;
        d_shamt = 5'(sh);
        d_op    = op;
        n = 0;
        forever begin
            @(negedge clk);
            if (i_ready) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got in_ready 0 expected 1");
                @(posedge clk);
                #1;
                d_valid = 1'b0;
                return;
            end
        end
        q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        d_valid = 1'b0;
        d_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(q.size()), 32'h0);
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] e;
    } vec_t;

    vec_t v32[10] = '{
        '{32'h8000_0001, 5'd1,  2'b01, 32'h4000_0000},
        '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF},
        '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000},
        '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000},
        '{32'h8000_0000, 5'd1,  2'b00, 32'h0000_0000},
        '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF},
        '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF},
        '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF},
        '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF},
        '{32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456}
    };

    vec_t v8[10] = '{
        '{32'h81, 5'd1, 2'b01, 32'h40},
        '{32'h80, 5'd7, 2'b10, 32'hFF},
        '{32'h01, 5'd1, 2'b11, 32'h80},
        '{32'h01, 5'd7, 2'b00, 32'h80},
        '{32'h80, 5'd1, 2'b00, 32'h00},
        '{32'hEF, 5'd0, 2'b00, 32'hEF},
        '{32'hEF, 5'd0, 2'b01, 32'hEF},
        '{32'hEF, 5'd0, 2'b10, 32'hEF},
        '{32'hEF, 5'd0, 2'b11, 32'hEF},
        '{32'h12, 5'd4, 2'b11, 32'h21}
    };

    task automatic run_suite(int w);
        int shw;
        int n;
        int acc;
        int c0;
        logic [31:0] mask;
        logic [31:0] a;
        int sh;
        logic [1:0] op;
        vec_t v;

        w8   = (w == 8);
        shw  = (w == 8) ? 3 : 5;
        mask = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
        d_ready = 1'b1;
        #1;

        // latency from acceptance into an empty pipe
        send(32'h0000_00F0, 4, 2'b01, 32'h0000_000F);
        d_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_valid || n > 20) break;
            n++;
        end
        check("latency", 32'(n), 32'(shw - 1));
        drain();

        // directed vectors, back to back
        for (int i = 0; i < 10; i++) begin
            v = (w == 8) ? v8[i] : v32[i];
            check("model_vs_table", model(v.a, int'(v.sh), v.op, w), v.e);
            send(v.a, int'(v.sh), v.op, v.e);
        end
        drain();

        // 100 random ops, one per cycle
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            a  = $urandom() & mask;
            sh = $urandom_range(0, w - 1);
            op = 2'($urandom_range(0, 3));
            send(a, sh, op, model(a, sh, op, w));
        end
        check("stream_cycles", 32'(cyc - c0), 32'd100);
        d_valid = 1'b0;
        repeat (shw) @(posedge clk);
        #1;
        check("stream_done", 32'(q.size()), 32'h0);

        // backpressure: out_ready low for 10 cycles
        d_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            a  = (32'hA5C3_0F01 + 32'(i * 7)) & mask;
            sh = (i * 3) % w;
            op = 2'(i);
            d_valid = 1'b1;
            d_a     = a;
            d_shamt = 5'(sh);
            d_op    = op;
            @(negedge clk);
            if (i_ready) begin
                q.push_back(model(a, sh, op, w));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_in_ready", {31'h0, i_ready}, 32'h0);
        check("bp_accepted", 32'(acc), 32'(shw));
        @(posedge clk);
        #1;
        drain();

        // reset with three ops in flight
        d_ready = 1'b0;
        send(32'h0000_0011 & mask, 1, 2'b00, 32'h0000_0022);
        send(32'h0000_0044 & mask, 2, 2'b01, 32'h0000_0011);
        send(32'h0000_0081 & mask, 1, 2'b11, (w == 8) ? 32'hC0 : 32'h8000_0040);
        d_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {31'h0, o_valid}, 32'h0);
        check("rst_out_result", o_result, 32'h0);
        check("rst_out_zero", {31'h0, o_zero}, 32'h1);
        check("rst_in_ready", {31'h0, i_ready}, 32'h1);
        d_ready = 1'b1;
        send(32'h0000_0006, 1, 2'b01, 32'h0000_0003);
        drain();
    endtask

    initial begin
        rst     = 1'b1;
        w8      = 1'b0;
        d_valid = 1'b0;
        d_ready = 1'b1;
        d_a     = '0;
        d_shamt = '0;
        d_op    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            w8 = (s == 1);
            #1;
            check("reset_out_valid", {31'h0, o_valid}, 32'h0);
            check("reset_out_result", o_result, 32'h0);
            check("reset_out_zero", {31'h0, o_zero}, 32'h1);
            check("reset_in_ready", {31'h0, i_ready}, 32'h1);
        end
        @(posedge clk);
        #1;
        run_suite(32);
        run_suite(8);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, pipelined barrel shifter for the ALU. It supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. It has one pipeline stage per shift-amount bit and a valid/ready handshake on both sides, so it accepts one operation per cycle and stalls cleanly under backpressure. It sits beside the adder in the ALU execute path and generalises the fixed 32-bit combinational logical right shifter with width, mode and pipelining.

## Interface
- WIDTH, 32: operand width in bits. Must be a power of two, at least 4.
- SHW, log2(WIDTH): localparam, not overridable. It sets the shift-amount width and the pipeline depth.
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  an operation is presented on in_a / in_shamt / in_op.
- in_ready  output  1  the block accepts the operation this cycle.
- in_a  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  2  operation select:
  - 00: SLL, logical left.
  - 01: SRL, logical right.
  - 10: SRA, arithmetic right.
  - 11: ROR, rotate right.
- out_valid  output  1  out_result holds a completed operation.
- out_ready  input  1  the downstream block consumes out_result this cycle.
- out_result  output  WIDTH  shifted value.
- out_zero  output  1  out_result is all zeros.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
- The pipeline has SHW register stages, numbered 0..SHW-1.
  - Stage k applies a shift of 2^k positions when shamt bit k is 1, and passes the data through unchanged otherwise.
  - Each stage register holds: valid, data, the remaining shamt bits, op, and the original operand MSB (sign).
- When adv = 1, every stage loads from its predecessor. Stage 0 loads the input, with valid = in_valid.
- When adv = 0, every stage holds its value. Bubbles are not compressed.
- Per-stage function for a shift by s:
  - SLL: zeros fill from the LSB.
  - SRL: zeros fill from the MSB.
  - SRA: the sign bit captured at entry fills from the MSB. The sign is not re-read from intermediate data, although it is identical.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- in_shamt = 0 returns in_a unchanged for all ops.
- The overall result equals the single-step reference:
  - SLL: a << shamt.
  - SRL: a >> shamt.
  - SRA: $signed(a) >>> shamt.
  - ROR: (a >> shamt) | (a << (WIDTH - shamt)), with shamt = 0 giving a.
- The last stage drives the outputs directly: out_result, out_valid and out_zero = (out_result == 0). out_zero is registered or computed from the last stage's data.
- Data in a stage whose valid = 0 is don't-care, except that it is 0 after reset.
- Reset (rst = 1 at a rising edge):
  - All stage valid bits and data clear to 0.
  - out_valid = 0, out_result = 0, out_zero = 1.
  - in_ready = 1 the following cycle.
- Reset mid-operation drops all in-flight operations without producing any output.
- If an input and an output transfer occur in the same cycle, both complete and the pipeline advances one slot.

## Timing
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+SHW-1, i.e. SHW register stages. For WIDTH = 32 that is 5 edges from acceptance into stage 0 to presence in stage 4.
- Throughput: one operation per cycle while out_ready = 1.
- in_ready depends combinationally on out_valid and out_ready only, never on in_valid.
- out_valid, out_result and out_zero are stable while out_valid = 1 and out_ready = 0.
- Full occupancy with out_ready = 0:
  - in_ready = 0.
  - Up to SHW operations are held, with no loss and no duplication.
  - Releasing out_ready resumes in order, at one per cycle.

## Test plan
- SRL, WIDTH = 32: a = 0x8000_0001, shamt = 1 -> out_result = 0x4000_0000 after 5 stages, out_zero = 0.
- SRA and ROR, WIDTH = 32:
  - SRA with a = 0x8000_0000, shamt = 31 -> 0xFFFF_FFFF.
  - ROR with a = 0x0000_0001, shamt = 1 -> 0x8000_0000.
  - SLL with a = 0x0000_0001, shamt = 31 -> 0x8000_0000.
  - SLL with a = 0x8000_0000, shamt = 1 -> 0x0000_0000 with out_zero = 1.
- Back-to-back streaming: 100 random (a, shamt, op) triples with in_valid = 1 and out_ready = 1 every cycle -> results arrive in order, one per cycle, each matching the reference model.
- Backpressure: stream continuously and hold out_ready = 0 for 10 cycles -> in_ready = 0 once SHW operations are in flight, out_result is held constant, and no result is lost or repeated after release.
- Reset mid-stream: assert rst for 1 cycle while 3 operations are in flight -> out_valid = 0, out_result = 0 and out_zero = 1 next cycle, with no stale results afterwards.
- shamt = 0 for each op with a = 0xDEAD_BEEF -> 0xDEAD_BEEF for all four ops. Repeat the whole suite with WIDTH = 8 (latency 3).
